// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 inverse cipher core.
package aes_pkg;

   typedef enum logic [1:0] {IDLE, KEYGEN, ROUND, DONE} state_e;

   // Index 0 and 11..15 are padding so a 4-bit round index never reads out of range.
   localparam logic [7:0] RCON [16] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   // Source byte for each destination byte of InvShiftRows (byte i = row + 4*col).
   localparam int ISR_MAP [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul9(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] mul11(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] mul13(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] mul14(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3),
              mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
              mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3),
              mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3)};
   endfunction

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box: combinational 256-entry lookup, entry 0 in the top byte of the table.
module inv_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);

   localparam logic [2047:0] TABLE = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   logic [10:0] idx;

   assign idx = {~a_i, 3'b000};
   assign y_o = TABLE[idx +: 8];

endmodule

// File: rtl/sbox.sv
// AES forward S-box: combinational 256-entry lookup, entry 0 in the top byte of the table.
module sbox (
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);

   localparam logic [2047:0] TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [10:0] idx;

   assign idx = {~a_i, 3'b000};
   assign y_o = TABLE[idx +: 8];

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption core, one round per clock, valid/ready on both sides.
// Optional AES_INV_KEYGEN_EN: in_key is the cipher key, expanded on chip before the rounds.
module aes_inv_cipher
   import aes_pkg::*;
#(
   parameter int NR     = 10,
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DATA_W-1:0] in_key,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   localparam logic [3:0] LAST_RND = 4'(NR - 1);

   state_e            state_q, state_d;
   logic [3:0]        ctr_q, ctr_d;
   logic [DATA_W-1:0] st_q, st_d;
   logic [DATA_W-1:0] rk_q, rk_d;
   logic [DATA_W-1:0] out_q, out_d;

   logic [31:0]       k0, k1, k2, k3, krev3;
   logic [31:0]       sb_in, rot_w, sub_w, rc_w;
   logic [DATA_W-1:0] rk_rev;
   logic [DATA_W-1:0] isb_w, ark, imc, rnd_out;

   assign {k0, k1, k2, k3} = rk_q;
   assign krev3 = k3 ^ k2;
   assign rc_w  = {RCON[ctr_q + 4'd1], 24'h000000};

`ifdef AES_INV_KEYGEN_EN
   logic [31:0]       f0, f1, f2, f3;
   logic [DATA_W-1:0] rk_fwd;

   // The four key-path S-boxes serve forward expansion in KEYGEN and the reverse step in ROUND.
   assign sb_in  = (state_q == KEYGEN) ? k3 : krev3;
   assign f0     = k0 ^ sub_w ^ rc_w;
   assign f1     = k1 ^ f0;
   assign f2     = k2 ^ f1;
   assign f3     = k3 ^ f2;
   assign rk_fwd = {f0, f1, f2, f3};
`else
   assign sb_in  = krev3;
`endif

   assign rot_w  = {sb_in[23:0], sb_in[31:24]};
   assign rk_rev = {k0 ^ sub_w ^ rc_w, k1 ^ k0, k2 ^ k1, krev3};

   for (genvar g = 0; g < 4; g++) begin : g_key_sbox
      sbox u_sbox (
         .a_i (rot_w[31-8*g -: 8]),
         .y_o (sub_w[31-8*g -: 8])
      );
   end

   // InvShiftRows is pure wiring: each inverse S-box reads its shifted source byte directly.
   for (genvar g = 0; g < 16; g++) begin : g_inv_sbox
      inv_sbox u_inv_sbox (
         .a_i (st_q[DATA_W-1-8*ISR_MAP[g] -: 8]),
         .y_o (isb_w[DATA_W-1-8*g -: 8])
      );
   end

   assign ark = isb_w ^ rk_rev;

   for (genvar c = 0; c < 4; c++) begin : g_inv_mix
      assign imc[DATA_W-1-32*c -: 32] = inv_mix_col(ark[DATA_W-1-32*c -: 32]);
   end

   assign rnd_out = (ctr_q == 4'd0) ? ark : imc;

   always_comb begin
      state_d = state_q;
      ctr_d   = ctr_q;
      st_d    = st_q;
      rk_d    = rk_q;
      out_d   = out_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
`ifdef AES_INV_KEYGEN_EN
               st_d    = in_data;
               rk_d    = in_key;
               ctr_d   = 4'd0;
               state_d = KEYGEN;
`else
               st_d    = in_data ^ in_key;
               rk_d    = in_key;
               ctr_d   = LAST_RND;
               state_d = ROUND;
`endif
            end
         end
`ifdef AES_INV_KEYGEN_EN
         KEYGEN: begin
            rk_d = rk_fwd;
            if (ctr_q == LAST_RND) begin
               st_d    = st_q ^ rk_fwd;
               state_d = ROUND;
            end else begin
               ctr_d = ctr_q + 4'd1;
            end
         end
`endif
         ROUND: begin
            st_d = rnd_out;
            rk_d = rk_rev;
            if (ctr_q == 4'd0) begin
               out_d   = rnd_out;
               state_d = DONE;
            end else begin
               ctr_d = ctr_q - 4'd1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ctr_q   <= 4'd0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
         out_q   <= out_d;
      end
   end

   always_ff @(posedge clk) begin
      st_q <= st_d;
      rk_q <= rk_d;
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_data  = out_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Scoreboard bench for aes_inv_cipher: FIPS-197 vectors, backpressure, mid-run reset and
// back-to-back blocks produced by an independent forward AES-128 model.
module tb_aes_inv_cipher;

`ifdef AES_INV_KEYGEN_EN
   localparam int LAT = 21;
`else
   localparam int LAT = 11;
`endif

   typedef struct packed {
      logic [127:0] ct;
      logic [127:0] rk10;
      logic [127:0] ck;
      logic [127:0] pt;
   } vec_t;

   typedef struct {
      logic [127:0] pt;
      int unsigned  due;
   } exp_t;

   localparam logic [2047:0] SBOX_T = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, out_valid, out_ready;
   logic [127:0] in_data, in_key, out_data;

   int unsigned  cyc   = 0;
   int unsigned  n_cmp = 0;
   int unsigned  n_err = 0;
   exp_t         sb_q [$];

   aes_inv_cipher dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_key    (in_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, expected it to finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- forward AES-128 reference model ----------------
   function automatic logic [7:0] m_sbox(input logic [7:0] a);
      logic [10:0] idx;
      idx = {~a, 3'b000};
      return SBOX_T[idx +: 8];
   endfunction

   function automatic logic [7:0] m_x2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] m_next_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, t;
      {w0, w1, w2, w3} = k;
      t  = {m_sbox(w3[23:16]), m_sbox(w3[15:8]), m_sbox(w3[7:0]), m_sbox(w3[31:24])} ^ {rc, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic void m_encrypt(input logic [127:0] key, input logic [127:0] pt,
                                     output logic [127:0] ct, output logic [127:0] rk10);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3, rc;
      logic [127:0] k;
      k  = key;
      rc = 8'h01;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = m_sbox(s[i]);
         for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
               s[row + 4*col] = t[row + 4*((col + row) % 4)];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = m_x2(a0) ^ m_x2(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ m_x2(a1) ^ m_x2(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ m_x2(a2) ^ m_x2(a3) ^ a3;
               s[4*c+3] = m_x2(a0) ^ a0 ^ a1 ^ a2 ^ m_x2(a3);
            end
         end
         k  = m_next_key(k, rc);
         rc = m_x2(rc);
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
      rk10 = k;
   endfunction

   function automatic logic [127:0] key_of(input vec_t v);
`ifdef AES_INV_KEYGEN_EN
      return v.ck;
`else
      return v.rk10;
`endif
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic check1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   // Called just after a posedge; returns just after the posedge that captured the block.
   task automatic send(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] pt,
                       output int unsigned acc);
      bit ok;
      ok       = 1'b0;
      acc      = 0;
      in_valid = 1'b1;
      in_data  = ct;
      in_key   = key;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
      end else begin
         acc = cyc;
         sb_q.push_back('{pt: pt, due: cyc + LAT});
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int i;
      i = 0;
      while (sb_q.size() != 0 && i < 400) begin @(negedge clk); i++; end
      if (sb_q.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL drain_timeout: %0d outputs outstanding, expected 0", sb_q.size());
      end
      @(posedge clk); #1;
   endtask

   // ---------------- monitor ----------------
   initial begin
      bit   ov_prev;
      exp_t e;
      ov_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ov_prev = 1'b0;
         end else begin
            if (out_valid && !ov_prev) begin
               if (sb_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL unexpected_out: out_valid=1 with data %h, expected no output", out_data);
               end else begin
                  check("latency", 128'(cyc), 128'(sb_q[0].due));
               end
            end
            if (out_valid && out_ready && sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check("out_data", out_data, e.pt);
            end
            ov_prev = out_valid;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      vec_t         c1, fb;
      int unsigned  acc, prev;
      bit           ok;
      logic [127:0] key, pt, ct, rk10, k_in;

      c1 = '{ct:   128'h69c4e0d86a7b0430d8cdb78070b4c55a,
             rk10: 128'h13111d7fe3944a17f307a78b4d2b30c5,
             ck:   128'h000102030405060708090a0b0c0d0e0f,
             pt:   128'h00112233445566778899aabbccddeeff};
      fb = '{ct:   128'h3925841d02dc09fbdc118597196a0b32,
             rk10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
             ck:   128'h2b7e151628aed2a6abf7158809cf4f3c,
             pt:   128'h3243f6a8885a308d313198a2e0370734};
      prev = 0;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_key    = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check1("reset_in_ready", in_ready, 1'b1);
      check1("reset_out_valid", out_valid, 1'b0);
      check("reset_out_data", out_data, 128'h0);
      @(posedge clk); #1;

      // FIPS-197 C.1 and Appendix B vectors
      send(c1.ct, key_of(c1), c1.pt, acc);
      drain();
      send(fb.ct, key_of(fb), fb.pt, acc);
      drain();

      // Backpressure: hold result, ignore a second request while DONE
      out_ready = 1'b0;
      send(c1.ct, key_of(c1), c1.pt, acc);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL bp_wait: out_valid stayed 0, expected 1");
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_data  = fb.ct;
         in_key   = key_of(fb);
         @(negedge clk);
         check1("bp_out_valid", out_valid, 1'b1);
         check("bp_out_data", out_data, c1.pt);
         check1("bp_in_ready", in_ready, 1'b0);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check1("bp_release_in_ready", in_ready, 1'b1);
      check1("bp_release_out_valid", out_valid, 1'b0);
      @(posedge clk); #1;

      // Reset while the core is at round 5, then a clean block
      send(c1.ct, key_of(c1), c1.pt, acc);
      repeat (LAT - 7) @(posedge clk);
      #1 rst = 1'b1;
      sb_q.delete();
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check1("midrst_out_valid", out_valid, 1'b0);
      check("midrst_out_data", out_data, 128'h0);
      check1("midrst_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      send(fb.ct, key_of(fb), fb.pt, acc);
      drain();

      // Back-to-back blocks from the forward model, out_ready held high
      for (int n = 0; n < 100; n++) begin
         key = {$urandom(), $urandom(), $urandom(), $urandom()};
         pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
         m_encrypt(key, pt, ct, rk10);
`ifdef AES_INV_KEYGEN_EN
         k_in = key;
`else
         k_in = rk10;
`endif
         send(ct, k_in, pt, acc);
         if (n > 0) check("b2b_spacing", 128'(acc - prev), 128'(LAT + 1));
         prev = acc;
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
